// File: rtl/sweep_pkg.sv
// Shared types and defaults for the frequency-sweep step controller.
package sweep_pkg;

    localparam int WIDTH_DEF   = 16;
    localparam int DWELL_W_DEF = 16;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_e;

endpackage

// File: rtl/sweep_step_ctrl_if.sv
// Command/config and step-output bundle between sweep master and controller.
interface sweep_step_ctrl_if #(
    parameter int WIDTH   = 16,
    parameter int DWELL_W = 16
);
    logic               start;
    logic               abort;
    logic               repeat_en;
    logic [WIDTH-1:0]   f_start;
    logic [WIDTH-1:0]   f_stop;
    logic [WIDTH-1:0]   f_inc;
    logic [DWELL_W-1:0] dwell;
    logic [WIDTH-1:0]   step;
    logic               busy;
    logic               done;
    logic               wrap;

    modport master (
        output start, abort, repeat_en,
        output f_start, f_stop, f_inc, dwell,
        input  step, busy, done, wrap
    );

    modport slave (
        input  start, abort, repeat_en,
        input  f_start, f_stop, f_inc, dwell,
        output step, busy, done, wrap
    );
endinterface

// File: rtl/sweep_dwell_timer.sv
// Loadable down-counter; tick marks the last cycle of a dwell period.
module sweep_dwell_timer #(
    parameter int DWELL_W = 16
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               load,
    input  logic [DWELL_W-1:0] load_val,
    input  logic               en,
    output logic               tick
);

    logic [DWELL_W-1:0] cnt_q;

    assign tick = en && (cnt_q == '0);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q <= '0;
        end else if (load) begin
            cnt_q <= load_val;
        end else if (en && (cnt_q != '0)) begin
            cnt_q <= cnt_q - 1'b1;
        end
    end

endmodule

// File: rtl/sweep_step_ctrl.sv
// Sweep FSM: latches a config, then steps f_start..f_stop with clamping,
// holding each value dwell+1 cycles; one-shot or repeating, abortable.
module sweep_step_ctrl
    import sweep_pkg::*;
#(
    parameter int WIDTH   = WIDTH_DEF,
    parameter int DWELL_W = DWELL_W_DEF
) (
    input  logic clk,
    input  logic reset,
    sweep_step_ctrl_if.slave bus
);

    state_e             state_q, state_d;
    logic [WIDTH-1:0]   step_q, step_d;
    logic               busy_q, done_q, done_d, wrap_q, wrap_d;

    logic [WIDTH-1:0]   fstart_q, fstop_q, finc_q;
    logic [DWELL_W-1:0] dwell_q;
    logic               rep_q, up_q;
    logic               cfg_ld;

    logic               tmr_load, tmr_en, tick;
    logic [DWELL_W-1:0] tmr_val;

    logic [WIDTH:0]     sum_w, diff_w;
    logic [WIDTH-1:0]   up_next, dn_next;

    sweep_dwell_timer #(.DWELL_W(DWELL_W)) u_timer (
        .clk      (clk),
        .reset    (reset),
        .load     (tmr_load),
        .load_val (tmr_val),
        .en       (tmr_en),
        .tick     (tick)
    );

    assign tmr_en  = (state_q == RUN);
    assign tmr_val = (state_q == IDLE) ? bus.dwell : dwell_q;

    // Extra MSB catches carry/borrow so the step never wraps past f_stop.
    // A zero increment would stall forever, so it jumps straight to f_stop.
    always_comb begin
        sum_w   = {1'b0, step_q} + {1'b0, finc_q};
        diff_w  = {1'b0, step_q} - {1'b0, finc_q};
        up_next = (sum_w[WIDTH] || (sum_w[WIDTH-1:0] > fstop_q)
                   || (finc_q == '0)) ? fstop_q : sum_w[WIDTH-1:0];
        dn_next = (diff_w[WIDTH] || (diff_w[WIDTH-1:0] < fstop_q)
                   || (finc_q == '0)) ? fstop_q : diff_w[WIDTH-1:0];
    end

    always_comb begin
        state_d  = state_q;
        step_d   = step_q;
        done_d   = 1'b0;
        wrap_d   = 1'b0;
        cfg_ld   = 1'b0;
        tmr_load = 1'b0;
        if (bus.abort) begin
            state_d = IDLE;
            step_d  = '0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (bus.start) begin
                        cfg_ld   = 1'b1;
                        tmr_load = 1'b1;
                        step_d   = bus.f_start;
                        state_d  = RUN;
                    end
                end
                RUN: begin
                    if (tick) begin
                        tmr_load = 1'b1;
                        if (step_q == fstop_q) begin
                            if (rep_q) begin
                                step_d = fstart_q;
                                wrap_d = 1'b1;
                            end else begin
                                state_d = IDLE;
                                done_d  = 1'b1;
                            end
                        end else begin
                            step_d = up_q ? up_next : dn_next;
                        end
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            step_q  <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            wrap_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            step_q  <= step_d;
            busy_q  <= (state_d == RUN);
            done_q  <= done_d;
            wrap_q  <= wrap_d;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            fstart_q <= '0;
            fstop_q  <= '0;
            finc_q   <= '0;
            dwell_q  <= '0;
            rep_q    <= 1'b0;
            up_q     <= 1'b0;
        end else if (cfg_ld) begin
            fstart_q <= bus.f_start;
            fstop_q  <= bus.f_stop;
            finc_q   <= bus.f_inc;
            dwell_q  <= bus.dwell;
            rep_q    <= bus.repeat_en;
            up_q     <= (bus.f_stop >= bus.f_start);
        end
    end

    assign bus.step = step_q;
    assign bus.busy = busy_q;
    assign bus.done = done_q;
    assign bus.wrap = wrap_q;

endmodule
